// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory copy engine, data memory and port mux.
package dmem_pkg;

  localparam int MEM_WORDS_DEF = 128;
  localparam int WORD_W        = 16;
  localparam int ADDR_W        = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WRITE,
    S_DONE
  } copy_state_e;

endpackage

// File: rtl/dmem_copy_engine.sv
// Block-copy initiator for the single-port data memory with memmove semantics.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; latches src/dst/len and clears err
// S_CHECK | range check and copy-direction selection, no memory access
// S_READ  | read strobe at src+offset
// S_WRITE | write strobe at dst+offset with the returned read data
// S_DONE  | one-cycle completion pulse
module dmem_copy_engine
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [WORD_W-1:0] mem_data_in
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS);

  copy_state_e       state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              bwd_q, bwd_d;
  logic              err_q, err_d;

  logic [ADDR_W:0]   src_end;
  logic [ADDR_W:0]   dst_end;
  logic              range_bad;
  logic              overlap_up;

  // Range and overlap checks on the latched request; 17-bit sums cannot wrap.
  always_comb begin
    src_end    = {1'b0, src_q} + {1'b0, rem_q};
    dst_end    = {1'b0, dst_q} + {1'b0, rem_q};
    range_bad  = (src_end > LIMIT) || (dst_end > LIMIT);
    overlap_up = (dst_q > src_q) && ({1'b0, dst_q} < src_end);
  end

  // Next-state, datapath updates and memory-port outputs.
  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    off_d          = off_q;
    rem_d          = rem_q;
    bwd_d          = bwd_q;
    err_d          = err_q;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src;
          dst_d   = dst;
          rem_d   = len;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (range_bad) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          // Destination above an overlapping source must be copied top-down.
          bwd_d   = overlap_up;
          off_d   = overlap_up ? rem_q - 1'b1 : '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        mem_read = 1'b1;
        mem_addr = src_q + off_q;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        mem_write      = 1'b1;
        mem_addr       = dst_q + off_q;
        mem_write_data = mem_data_in;
        if (rem_q == 16'd1) begin
          state_d = S_DONE;
        end else begin
          rem_d   = rem_q - 1'b1;
          off_d   = bwd_q ? off_q - 1'b1 : off_q + 1'b1;
          state_d = S_READ;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      off_q   <= '0;
      rem_q   <= '0;
      bwd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      off_q   <= off_d;
      rem_q   <= rem_d;
      bwd_q   <= bwd_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench for dmem_copy_engine: directed cases then random copies
// against a memmove reference model of the data memory.
module tb_dmem_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src, dst, len;
  logic        busy, done, err;
  logic [15:0] mem_addr, mem_write_data, mem_data_in;
  logic        mem_write, mem_read;

  logic        init_mem;
  logic [15:0] mem     [128];
  logic [15:0] ref_mem [128];
  logic [15:0] rd_q;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_copy_engine #(.MEM_WORDS(128)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .src            (src),
    .dst            (dst),
    .len            (len),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_data_in    (mem_data_in)
  );

  // Data memory model: registered read, write on edge, preload k at address k.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 128; k++) mem[k] <= 16'(k);
      rd_q <= '0;
    end else begin
      if (mem_read && int'(mem_addr) < 128) rd_q <= mem[int'(mem_addr)];
      if (mem_write && int'(mem_addr) < 128) mem[int'(mem_addr)] <= mem_write_data;
    end
  end
  assign mem_data_in = rd_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    int bad = 0;
    for (int k = 0; k < 128; k++) if (mem[k] !== ref_mem[k]) bad++;
    chk({tag, "/mem_words_wrong"}, 32'(bad), 0);
  endtask

  // Caller is at a negedge in an IDLE cycle. rst_at>0 asserts reset during that
  // cycle number; poke pulses start again mid-copy.
  task automatic run_copy(input int s, input int d, input int n,
                          input int rst_at, input bit poke, input string tag);
    logic [15:0] old [128];
    bit exp_err, bwd;
    int ops, exp_done, rd_i, wr_i, done_k, off, limit;
    old      = ref_mem;
    exp_err  = (s + n > 128) || (d + n > 128);
    ops      = (exp_err || n == 0) ? 0 : n;
    exp_done = (ops == 0) ? 2 : 2 * n + 2;
    bwd      = (d > s) && (d < s + n);
    limit    = exp_done + 5;
    rd_i = 0; wr_i = 0; done_k = 0;

    start = 1'b1; src = 16'(s); dst = 16'(d); len = 16'(n);
    @(negedge clk);
    start = 1'b0; src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom);

    for (int k = 1; k <= limit; k++) begin
      if (rst_at != 0 && k == rst_at + 1) begin
        chk({tag, "/rst_busy"}, 32'(busy), 0);
        chk({tag, "/rst_done"}, 32'(done), 0);
        chk({tag, "/rst_err"}, 32'(err), 0);
        chk({tag, "/rst_strobes"}, {30'd0, mem_read, mem_write}, 0);
        chk({tag, "/rst_addr"}, 32'(mem_addr), 0);
        chk({tag, "/rst_wdata"}, 32'(mem_write_data), 0);
        reset = 1'b0;
        break;
      end
      chk({tag, "/busy"}, 32'(busy), 1);
      chk({tag, "/rw_excl"}, 32'(mem_read & mem_write), 0);
      if (k == 1) chk({tag, "/err_cleared"}, 32'(err), 0);
      if (mem_read) begin
        off = bwd ? n - 1 - rd_i : rd_i;
        chk({tag, "/rd_cycle"}, 32'(k), 32'(2 + 2 * rd_i));
        chk({tag, "/rd_addr"}, 32'(mem_addr), 32'(s + off));
        rd_i++;
      end else if (mem_write) begin
        off = bwd ? n - 1 - wr_i : wr_i;
        chk({tag, "/wr_cycle"}, 32'(k), 32'(3 + 2 * wr_i));
        chk({tag, "/wr_addr"}, 32'(mem_addr), 32'(d + off));
        chk({tag, "/wr_data"}, 32'(mem_write_data), 32'(old[s + off]));
        wr_i++;
      end else begin
        chk({tag, "/idle_port"}, {mem_addr, mem_write_data}, 0);
      end
      if (done) begin
        done_k = k;
        break;
      end
      if (k == rst_at) reset = 1'b1;
      if (poke && k == 3) begin start = 1'b1; src = 16'd0; dst = 16'd100; len = 16'd3; end
      if (poke && k == 4) start = 1'b0;
      @(negedge clk);
    end

    if (rst_at == 0) begin
      chk({tag, "/done_cycle"}, 32'(done_k), 32'(exp_done));
      chk({tag, "/err"}, 32'(err), 32'(exp_err));
      chk({tag, "/reads"}, 32'(rd_i), 32'(ops));
      chk({tag, "/writes"}, 32'(wr_i), 32'(ops));
      for (int i = 0; i < ops; i++) ref_mem[d + i] = old[s + i];
      @(negedge clk);
      chk({tag, "/post_busy"}, 32'(busy), 0);
      chk({tag, "/post_done"}, 32'(done), 0);
      chk({tag, "/post_err"}, 32'(err), 32'(exp_err));
    end else begin
      for (int i = 0; i < n && (2 * i + 3) <= rst_at; i++) begin
        off = bwd ? n - 1 - i : i;
        ref_mem[d + off] = old[s + off];
      end
      @(negedge clk);
    end
    chk_mem(tag);
  endtask

  initial begin
    int s, d, n;
    reset = 1'b1; init_mem = 1'b1;
    start = 1'b0; src = '0; dst = '0; len = '0;
    for (int k = 0; k < 128; k++) ref_mem[k] = 16'(k);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset/busy", 32'(busy), 0);
    chk("reset/done", 32'(done), 0);
    chk("reset/err", 32'(err), 0);
    chk("reset/strobes", {30'd0, mem_read, mem_write}, 0);
    chk("reset/addr", 32'(mem_addr), 0);
    chk("reset/wdata", 32'(mem_write_data), 0);
    reset = 1'b0; init_mem = 1'b0;
    @(negedge clk);

    run_copy(10, 50, 4, 0, 1'b0, "fwd");
    run_copy(20, 22, 5, 0, 1'b0, "ovl_up");
    chk("ovl_up/m20", 32'(mem[20]), 32'd20);
    chk("ovl_up/m26", 32'(mem[26]), 32'd24);
    run_copy(30, 28, 4, 0, 1'b0, "ovl_dn");
    chk("ovl_dn/m31", 32'(mem[31]), 32'd33);
    chk("ovl_dn/m32", 32'(mem[32]), 32'd32);
    run_copy(5, 60, 0, 0, 1'b0, "len0");
    run_copy(120, 0, 10, 0, 1'b0, "range_err");
    repeat (3) begin
      @(negedge clk);
      chk("range_err/hold", 32'(err), 1);
    end
    run_copy(40, 70, 4, 0, 1'b1, "start_mid");
    run_copy(80, 90, 4, 4, 1'b0, "reset_mid");
    run_copy(80, 90, 4, 0, 1'b0, "after_reset");
    run_copy(0, 0, 3, 0, 1'b0, "same");

    for (int it = 0; it < 30; it++) begin
      s = int'($urandom_range(0, 127));
      n = (it % 5 == 4) ? int'($urandom_range(0, 140)) : int'($urandom_range(0, 12));
      if (it % 2 == 0) begin
        d = s + int'($urandom_range(0, 8)) - 4;
        if (d < 0) d = 0;
        if (d > 127) d = 127;
      end else begin
        d = int'($urandom_range(0, 127));
      end
      run_copy(s, d, n, 0, 1'b0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
